// File: rtl/video_timing_recover_if.sv
// Video timing bus: raw syncs in, recovered counts,
// measurements and lock status out.
interface video_timing_recover_if #(
  parameter int HW = 12,
  parameter int VW = 11
);
  logic          hs_in;
  logic          vs_in;
  logic          ad_in;
  logic [HW-1:0] hcount_out;
  logic [VW-1:0] vcount_out;
  logic          ad_out;
  logic [HW-1:0] h_active_out;
  logic [HW-1:0] h_total_out;
  logic [VW-1:0] v_active_out;
  logic [VW-1:0] v_total_out;
  logic          locked_out;
  logic          nf_out;
  logic [5:0]    fc_out;

  modport master (
    output hs_in,
    output vs_in,
    output ad_in,
    input  hcount_out,
    input  vcount_out,
    input  ad_out,
    input  h_active_out,
    input  h_total_out,
    input  v_active_out,
    input  v_total_out,
    input  locked_out,
    input  nf_out,
    input  fc_out
  );

  modport slave (
    input  hs_in,
    input  vs_in,
    input  ad_in,
    output hcount_out,
    output vcount_out,
    output ad_out,
    output h_active_out,
    output h_total_out,
    output v_active_out,
    output v_total_out,
    output locked_out,
    output nf_out,
    output fc_out
  );
endinterface

// File: rtl/video_timing_recover.sv
// Recovers pixel/line position from hs/vs/ad, measures
// frame geometry and locks once it is stable.
module video_timing_recover #(
  parameter int HW          = 12,
  parameter int VW          = 11,
  parameter int FPS         = 60,
  parameter int LOCK_FRAMES = 2,
  parameter int WD_W        = 24
) (
  input logic pixel_clk_in,
  input logic rst_n_in,
  video_timing_recover_if.slave bus
);

  localparam int MW =
    (LOCK_FRAMES < 2) ? 1 : $clog2(LOCK_FRAMES);
  localparam logic [MW-1:0] M_LAST =
    MW'(LOCK_FRAMES - 1);
  localparam logic [HW-1:0] H_MAX = '1;
  localparam logic [VW-1:0] V_MAX = '1;
  localparam logic [WD_W-1:0] WD_MAX = '1;
  localparam logic [5:0] FC_LAST = 6'(FPS - 1);

  typedef enum logic [1:0] {
    SEARCH,
    MEASURE,
    LOCKED
  } state_t;

  state_t state, state_n;

  logic hs_q, vs_q, ad_q;
  logic hs_rise, vs_rise, ad_rise, ad_fall;

  logic [HW-1:0] hcount;
  logic [VW-1:0] vcount;
  logic          ad_d;
  logic          first_pend;
  logic          line_seen;

  logic [HW-1:0] cnt_ha, meas_ha;
  logic [HW-1:0] cnt_ht, meas_ht;
  logic [VW-1:0] cnt_va, cnt_vt;

  logic [HW-1:0] h_active, h_total;
  logic [VW-1:0] v_active, v_total;

  logic [WD_W-1:0] wd;
  logic [MW-1:0]   mcnt, mcnt_n;
  logic            have_prev, have_prev_n;
  logic            nf, nf_n;
  logic [5:0]      fc;
  logic            upd;

  logic frame_match;
  logic ht_bad;
  logic wd_exp;

  assign hs_rise = bus.hs_in & ~hs_q;
  assign vs_rise = bus.vs_in & ~vs_q;
  assign ad_rise = bus.ad_in & ~ad_q;
  assign ad_fall = ~bus.ad_in & ad_q;

  assign frame_match = (meas_ha == h_active)
                    && (meas_ht == h_total)
                    && (cnt_va == v_active)
                    && (cnt_vt == v_total);

  // A vs rise starts a new frame, so its ad rise is never
  // compared against the line length.
  assign ht_bad = ad_rise && line_seen && !vs_rise
               && (cnt_ht != h_total);

  assign wd_exp = (wd == WD_MAX) && !vs_rise;

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      hs_q       <= 1'b0;
      vs_q       <= 1'b0;
      ad_q       <= 1'b0;
      ad_d       <= 1'b0;
      hcount     <= '0;
      vcount     <= '0;
      first_pend <= 1'b0;
      line_seen  <= 1'b0;
    end else begin
      hs_q <= bus.hs_in;
      vs_q <= bus.vs_in;
      ad_q <= bus.ad_in;
      ad_d <= bus.ad_in;

      if (ad_rise)
        hcount <= '0;
      else if (hcount != H_MAX)
        hcount <= hcount + 1'b1;

      if (ad_rise) begin
        if (vs_rise || first_pend)
          vcount <= '0;
        else if (vcount != V_MAX)
          vcount <= vcount + 1'b1;
      end

      if (vs_rise)
        first_pend <= !ad_rise;
      else if (ad_rise)
        first_pend <= 1'b0;

      if (vs_rise)
        line_seen <= ad_rise;
      else if (ad_rise)
        line_seen <= 1'b1;
    end
  end

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cnt_ha  <= '0;
      meas_ha <= '0;
      cnt_ht  <= '0;
      meas_ht <= '0;
      cnt_va  <= '0;
      cnt_vt  <= '0;
      wd      <= '0;
    end else begin
      if (ad_rise)
        cnt_ha <= HW'(1);
      else if (bus.ad_in && cnt_ha != H_MAX)
        cnt_ha <= cnt_ha + 1'b1;

      if (ad_fall)
        meas_ha <= cnt_ha;

      if (ad_rise)
        cnt_ht <= HW'(1);
      else if (cnt_ht != H_MAX)
        cnt_ht <= cnt_ht + 1'b1;

      if (ad_rise && line_seen && !vs_rise)
        meas_ht <= cnt_ht;

      if (vs_rise)
        cnt_va <= VW'(ad_rise);
      else if (ad_rise && cnt_va != V_MAX)
        cnt_va <= cnt_va + 1'b1;

      if (vs_rise)
        cnt_vt <= VW'(hs_rise);
      else if (hs_rise && cnt_vt != V_MAX)
        cnt_vt <= cnt_vt + 1'b1;

      if (vs_rise)
        wd <= '0;
      else if (wd != WD_MAX)
        wd <= wd + 1'b1;
    end
  end

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state     <= SEARCH;
      mcnt      <= '0;
      have_prev <= 1'b0;
    end else begin
      state     <= state_n;
      mcnt      <= mcnt_n;
      have_prev <= have_prev_n;
    end
  end

  always_comb begin
    state_n     = state;
    mcnt_n      = mcnt;
    have_prev_n = have_prev;
    upd         = 1'b0;
    nf_n        = 1'b0;
    if (wd_exp) begin
      state_n     = SEARCH;
      mcnt_n      = '0;
      have_prev_n = 1'b0;
    end else begin
      unique case (state)
        SEARCH: begin
          if (vs_rise)
            state_n = MEASURE;
        end
        MEASURE: begin
          if (vs_rise) begin
            upd         = 1'b1;
            have_prev_n = 1'b1;
            if (have_prev && frame_match) begin
              mcnt_n = mcnt + MW'(1);
              if (mcnt_n >= M_LAST)
                state_n = LOCKED;
            end else begin
              mcnt_n = '0;
            end
          end
        end
        LOCKED: begin
          if (vs_rise) begin
            nf_n = 1'b1;
            if (frame_match) begin
              upd = 1'b1;
            end else begin
              state_n     = SEARCH;
              mcnt_n      = '0;
              have_prev_n = 1'b0;
            end
          end else if (ht_bad) begin
            state_n     = SEARCH;
            mcnt_n      = '0;
            have_prev_n = 1'b0;
          end
        end
        default: begin
          state_n     = SEARCH;
          mcnt_n      = '0;
          have_prev_n = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      h_active <= '0;
      h_total  <= '0;
      v_active <= '0;
      v_total  <= '0;
      nf       <= 1'b0;
      fc       <= '0;
    end else begin
      if (upd) begin
        h_active <= meas_ha;
        h_total  <= meas_ht;
        v_active <= cnt_va;
        v_total  <= cnt_vt;
      end
      nf <= nf_n;
      if (nf_n)
        fc <= (fc == FC_LAST) ? '0 : fc + 1'b1;
    end
  end

  assign bus.hcount_out   = hcount;
  assign bus.vcount_out   = vcount;
  assign bus.ad_out       = ad_d;
  assign bus.h_active_out = h_active;
  assign bus.h_total_out  = h_total;
  assign bus.v_active_out = v_active;
  assign bus.v_total_out  = v_total;
  assign bus.locked_out   = (state == LOCKED);
  assign bus.nf_out       = nf;
  assign bus.fc_out       = fc;

endmodule

// File: tb/tb_video_timing_recover.sv
// Frame-level vector table plus watchdog and async
// reset sequences for video_timing_recover.
module tb_video_timing_recover;
  localparam int HW = 12;
  localparam int VW = 11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic hs = 1'b0;
  logic vs = 1'b0;
  logic ad = 1'b0;
  logic sel_wd = 1'b0;

  video_timing_recover_if #(.HW(HW), .VW(VW)) vif ();
  video_timing_recover_if #(.HW(HW), .VW(VW)) wif ();

  assign vif.hs_in = hs & ~sel_wd;
  assign vif.vs_in = vs & ~sel_wd;
  assign vif.ad_in = ad & ~sel_wd;
  assign wif.hs_in = hs & sel_wd;
  assign wif.vs_in = vs & sel_wd;
  assign wif.ad_in = ad & sel_wd;

  video_timing_recover #(.HW(HW), .VW(VW), .FPS(4)) dut (
    .pixel_clk_in (clk),
    .rst_n_in     (rst_n),
    .bus          (vif)
  );

  video_timing_recover #(.HW(HW), .VW(VW), .WD_W(8)) dut_wd (
    .pixel_clk_in (clk),
    .rst_n_in     (rst_n),
    .bus          (wif)
  );

  logic locked_s;
  logic nf_s;
  assign locked_s = sel_wd ? wif.locked_out : vif.locked_out;
  assign nf_s     = sel_wd ? wif.nf_out : vif.nf_out;

  typedef struct {
    int long_line;
    int rst_line;
    bit align;
    bit e_lock;
    bit e_unl;
    int e_nf;
    int e_fc;
    int e_ha;
    int e_ht;
    int e_va;
    int e_vt;
  } vec_t;

  vec_t tbl [16];

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_rise = 0;
  int nf_cnt = 0;
  bit unl = 1'b0;

  logic [HW-1:0] h0, hl;
  logic [VW-1:0] v0, v7;
  logic          adl;

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (!locked_s) unl = 1'b1;
    if (nf_s) nf_cnt++;
  endtask

  task automatic async_reset();
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_counts",
          {vif.hcount_out, vif.vcount_out, vif.ad_out}, 0);
    check("async_rst_meas",
          {vif.h_active_out, vif.h_total_out,
           vif.v_active_out, vif.v_total_out}, 0);
    check("async_rst_status",
          {vif.locked_out, vif.nf_out, vif.fc_out}, 0);
    #2 rst_n = 1'b1;
  endtask

  task automatic run_frame(input int ha, input int hfp,
                           input int hsw, input int hbp,
                           input int va, input int vfp,
                           input int vsw, input int vbp,
                           input int long_line,
                           input int rst_line);
    int  fp;
    int  tot;
    bit  vl;
    bit  rise;
    nf_cnt = 0;
    unl    = 1'b0;
    for (int l = 0; l < va + vfp + vsw + vbp; l++) begin
      vl  = (l >= va + vfp) && (l < va + vfp + vsw);
      fp  = hfp + ((l == long_line) ? 1 : 0);
      tot = ha + fp + hsw + hbp;
      for (int p = 0; p < tot; p++) begin
        rise = vl && !vs;
        ad = (l < va) && (p < ha);
        hs = (p >= ha + fp) && (p < ha + fp + hsw);
        vs = vl;
        tick();
        if (rise) last_rise = cyc;
        if (l == 0 && p == 0) begin
          h0 = vif.hcount_out;
          v0 = vif.vcount_out;
        end
        if (l == 0 && p == ha - 1) begin
          hl  = vif.hcount_out;
          adl = vif.ad_out;
        end
        if (l == va - 1 && p == 0) v7 = vif.vcount_out;
        if (l == rst_line && p == 5) async_reset();
      end
    end
    hs = 1'b0;
    ad = 1'b0;
    vs = 1'b0;
  endtask

  initial begin
    // long, rst, align, lock, unl, nf, fc, ha, ht, va, vt
    tbl[0]  = '{-1, -1, 0, 0, 1, 0, 0,  0,  0, 0,  0};
    tbl[1]  = '{-1, -1, 0, 0, 1, 0, 0, 16, 25, 8, 13};
    tbl[2]  = '{-1, -1, 0, 1, 1, 0, 0, 16, 25, 8, 13};
    tbl[3]  = '{-1, -1, 1, 1, 0, 1, 1, 16, 25, 8, 13};
    tbl[4]  = '{-1, -1, 0, 1, 0, 1, 2, 16, 25, 8, 13};
    tbl[5]  = '{-1, -1, 0, 1, 0, 1, 3, 16, 25, 8, 13};
    tbl[6]  = '{-1, -1, 0, 1, 0, 1, 0, 16, 25, 8, 13};
    tbl[7]  = '{-1, -1, 0, 1, 0, 1, 1, 16, 25, 8, 13};
    tbl[8]  = '{-1, -1, 0, 1, 0, 1, 2, 16, 25, 8, 13};
    tbl[9]  = '{ 3, -1, 0, 0, 1, 0, 2, 16, 25, 8, 13};
    tbl[10] = '{-1, -1, 0, 0, 1, 0, 2, 16, 25, 8, 13};
    tbl[11] = '{-1, -1, 0, 1, 1, 0, 2, 16, 25, 8, 13};
    tbl[12] = '{-1, -1, 1, 1, 0, 1, 3, 16, 25, 8, 13};
    tbl[13] = '{-1,  2, 0, 0, 1, 0, 0,  0,  0, 0,  0};
    tbl[14] = '{-1, -1, 0, 0, 1, 0, 0, 16, 25, 8, 13};
    tbl[15] = '{-1, -1, 0, 1, 1, 0, 0, 16, 25, 8, 13};

    repeat (3) @(posedge clk);
    #1;
    check("rst_counts",
          {vif.hcount_out, vif.vcount_out, vif.ad_out}, 0);
    check("rst_meas",
          {vif.h_active_out, vif.h_total_out,
           vif.v_active_out, vif.v_total_out}, 0);
    check("rst_status",
          {vif.locked_out, vif.nf_out, vif.fc_out,
           wif.locked_out}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) tick();

    for (int i = 0; i < 16; i++) begin
      run_frame(16, 2, 3, 4, 8, 1, 2, 2,
                tbl[i].long_line, tbl[i].rst_line);
      check($sformatf("f%0d_locked", i),
            vif.locked_out, tbl[i].e_lock);
      check($sformatf("f%0d_unlock_seen", i),
            unl, tbl[i].e_unl);
      check($sformatf("f%0d_nf_pulses", i),
            nf_cnt, tbl[i].e_nf);
      check($sformatf("f%0d_fc", i),
            vif.fc_out, tbl[i].e_fc);
      check($sformatf("f%0d_h_active", i),
            vif.h_active_out, tbl[i].e_ha);
      check($sformatf("f%0d_h_total", i),
            vif.h_total_out, tbl[i].e_ht);
      check($sformatf("f%0d_v_active", i),
            vif.v_active_out, tbl[i].e_va);
      check($sformatf("f%0d_v_total", i),
            vif.v_total_out, tbl[i].e_vt);
      if (tbl[i].align) begin
        check($sformatf("f%0d_hcount_first", i), h0, 0);
        check($sformatf("f%0d_vcount_first", i), v0, 0);
        check($sformatf("f%0d_hcount_last", i), hl, 15);
        check($sformatf("f%0d_ad_out_last", i), adl, 1);
        check($sformatf("f%0d_vcount_line7", i), v7, 7);
      end
    end

    // Short frames keep the 8-bit watchdog from expiring
    // while the second instance locks.
    sel_wd = 1'b1;
    for (int i = 0; i < 3; i++)
      run_frame(4, 1, 1, 1, 2, 1, 1, 1, -1, -1);
    check("wd_locked", locked_s, 1);
    check("wd_h_total", wif.h_total_out, 7);
    check("wd_v_total", wif.v_total_out, 5);
    while (cyc - last_rise < 250) tick();
    check("wd_hold_250", locked_s, 1);
    while (cyc - last_rise < 260) tick();
    check("wd_drop_260", locked_s, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
